// File: rtl/seq_detector_param_if.sv
// Serial input / match-result bundle for seq_detector_param.
// The optional pattern_mask signal exists only when SEQ_DET_MASK_EN is defined.
interface seq_detector_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             sequence_in;
    logic             in_valid;
    logic             pattern_ld;
    logic [PAT_W-1:0] pattern_in;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] pattern_mask;
`endif
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_cnt;

    modport master (
`ifdef SEQ_DET_MASK_EN
        output pattern_mask,
`endif
        output sequence_in,
        output in_valid,
        output pattern_ld,
        output pattern_in,
        output cnt_clr,
        input  out,
        input  match_cnt
    );

    modport slave (
`ifdef SEQ_DET_MASK_EN
        input  pattern_mask,
`endif
        input  sequence_in,
        input  in_valid,
        input  pattern_ld,
        input  pattern_in,
        input  cnt_clr,
        output out,
        output match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with a runtime-loadable pattern, a one-cycle match pulse and a saturating count.
// Define SEQ_DET_MASK_EN to add a per-bit don't-care mask loaded alongside the pattern.
module seq_detector_param #(
    parameter int unsigned      PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = 4'b0110,
    parameter bit               OVERLAP  = 1'b1,
    parameter int unsigned      CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    seq_detector_param_if.slave  bus
);
    localparam int unsigned     FW       = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_W);
    localparam logic [FW-1:0]   FILL_THR = FW'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] sr_q, sr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0] window;
    logic             hit;
    logic             match;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;
`endif

    // The incoming bit joins the window in the same cycle it is compared,
    // so a window that already holds PAT_W-1 bits can complete a match.
    always_comb begin
        window = {sr_q[PAT_W-2:0], bus.sequence_in};
`ifdef SEQ_DET_MASK_EN
        hit = (((window ^ pat_q) & mask_q) == '0);
`else
        hit = (window == pat_q);
`endif
        match = bus.in_valid && !bus.pattern_ld && (fill_q >= FILL_THR) && hit;
    end

    always_comb begin
        pat_d  = pat_q;
        sr_d   = sr_q;
        fill_d = fill_q;
        out_d  = match;
        cnt_d  = cnt_q;
`ifdef SEQ_DET_MASK_EN
        mask_d = mask_q;
`endif

        if (bus.pattern_ld) begin
            pat_d  = bus.pattern_in;
            sr_d   = '0;
            fill_d = '0;
`ifdef SEQ_DET_MASK_EN
            mask_d = bus.pattern_mask;
`endif
        end else if (bus.in_valid) begin
            if (match && !OVERLAP) begin
                sr_d   = '0;
                fill_d = '0;
            end else begin
                sr_d   = window;
                fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
            end
        end

        // Clear beats a same-cycle match; the pulse itself is unaffected.
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pat_q  <= PAT_INIT;
            sr_q   <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
            cnt_q  <= '0;
`ifdef SEQ_DET_MASK_EN
            mask_q <= '1;
`endif
        end else begin
            pat_q  <= pat_d;
            sr_q   <= sr_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
`ifdef SEQ_DET_MASK_EN
            mask_q <= mask_d;
`endif
        end
    end

    assign bus.out       = out_q;
    assign bus.match_cnt = cnt_q;
endmodule
